noc_switch_allocator: RTL

- Output-port allocator and flow-control scheduler for a 5-port wormhole NoC router (North, South, West, East, Local).
- Each cycle, decides which input queue head drives each output port and pops that input.
- Locks an output to one input from head flit to tail flit.
- Tracks per-output downstream credits (credit-based mode) or honours downstream stop (ack/nack mode).

---
 rtl/noc_switch_allocator_if.sv | 28 ++
 rtl/noc_switch_allocator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/noc_switch_allocator_if.sv
// Handshake bundle between the router input queues / downstream links and
// the switch allocator. Per-port vectors use bit order N,S,W,E,L = 0..4.
// req_preamble[i] is {head, tail}; req_dir[i] is a one-hot output select.
interface noc_switch_allocator_if #(
    parameter int CreditWidth = 3
);
    logic [4:0]                  req_valid;
    logic [4:0][4:0]             req_dir;
    logic [4:0][1:0]             req_preamble;
    logic [4:0]                  credit_in;
    logic [4:0]                  out_stop;
    logic [4:0]                  in_pop;
    logic [4:0]                  out_valid;
    logic [4:0][2:0]             out_sel;
    logic [4:0][CreditWidth-1:0] credits;

    // Router side: presents queue heads and downstream status, consumes grants.
    modport master (
        output req_valid, req_dir, req_preamble, credit_in, out_stop,
        input  in_pop, out_valid, out_sel, credits
    );

    // Allocator side.
    modport slave (
        input  req_valid, req_dir, req_preamble, credit_in, out_stop,
        output in_pop, out_valid, out_sel, credits
    );
endinterface

// File: rtl/noc_switch_allocator.sv
// Output-port allocator for a 5-port wormhole router. Each output picks one
// input head flit round-robin, locks to that input until the tail flit, and
// only transfers when downstream can accept (credits or !out_stop).
// FlowControl: 1 = credit-based, 0 = ack/nack (out_stop driven).
module noc_switch_allocator #(
    parameter bit         FlowControl    = 1'b1,
    parameter logic [4:0] Ports          = 5'b11111,
    parameter int         PortQueueDepth = 4
) (
    input logic                   clk,
    input logic                   rst,
    noc_switch_allocator_if.slave bus
);
    localparam bit kFlowControlCreditBased = 1'b1;
    localparam int CreditWidth = $clog2(PortQueueDepth + 1);
    localparam logic [CreditWidth-1:0] MaxCredits = CreditWidth'(PortQueueDepth);
    localparam logic [CreditWidth-1:0] OneCredit  = CreditWidth'(1);

    typedef enum logic {
        IDLE,
        LOCKED
    } out_state_e;

    out_state_e             state_q   [5];
    out_state_e             state_d   [5];
    logic [2:0]             owner_q   [5];
    logic [2:0]             owner_d   [5];
    logic [2:0]             rr_q      [5];
    logic [2:0]             rr_d      [5];
    logic [CreditWidth-1:0] credits_q [5];
    logic [CreditWidth-1:0] credits_d [5];

    logic [4:0]      locked_mask;
    logic [4:0]      can_send;
    logic [4:0]      cand      [5];
    logic [9:0]      cand_rot  [5];
    logic [2:0]      offset    [5];
    logic [3:0]      win_sum   [5];
    logic [2:0]      winner    [5];
    logic [4:0]      has_cand;
    logic [4:0]      pop_raw;
    logic [4:0]      valid_raw;
    logic [4:0][2:0] sel_raw;

    // Find eligible head flits per output and the round-robin winner among them.
    always_comb begin
        locked_mask = '0;
        for (int o = 0; o < 5; o++) begin
            if (state_q[o] == LOCKED) begin
                locked_mask[owner_q[o]] = 1'b1;
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (FlowControl == kFlowControlCreditBased) begin
                can_send[o] = (credits_q[o] != '0);
            end else begin
                can_send[o] = !bus.out_stop[o];
            end
            cand[o] = '0;
            for (int i = 0; i < 5; i++) begin
                cand[o][i] = bus.req_valid[i] && bus.req_preamble[i][1] &&
                             bus.req_dir[i][o] && Ports[i] && Ports[o] &&
                             ((i != o) || (i == 4)) && !locked_mask[i];
            end
            cand_rot[o] = {cand[o], cand[o]} >> rr_q[o];
            has_cand[o] = 1'b0;
            offset[o]   = '0;
            for (int j = 0; j < 5; j++) begin
                if (!has_cand[o] && cand_rot[o][j]) begin
                    has_cand[o] = 1'b1;
                    offset[o]   = 3'(j);
                end
            end
            win_sum[o] = {1'b0, rr_q[o]} + {1'b0, offset[o]};
            winner[o]  = (win_sum[o] >= 4'd5) ? 3'(win_sum[o] - 4'd5) : win_sum[o][2:0];
        end
    end

    // Per-output FSM: grant/transfer decisions, lock tracking and credit accounting.
    always_comb begin
        pop_raw   = '0;
        valid_raw = '0;
        sel_raw   = '0;
        for (int o = 0; o < 5; o++) begin
            state_d[o]   = state_q[o];
            owner_d[o]   = owner_q[o];
            rr_d[o]      = rr_q[o];
            credits_d[o] = credits_q[o];
            case (state_q[o])
                IDLE: begin
                    if (can_send[o] && has_cand[o]) begin
                        valid_raw[o]       = 1'b1;
                        sel_raw[o]         = winner[o];
                        pop_raw[winner[o]] = 1'b1;
                        rr_d[o] = (winner[o] == 3'd4) ? 3'd0 : winner[o] + 3'd1;
                        if (!bus.req_preamble[winner[o]][0]) begin
                            state_d[o] = LOCKED;
                            owner_d[o] = winner[o];
                        end
                    end
                end
                LOCKED: begin
                    if (bus.req_valid[owner_q[o]] && can_send[o]) begin
                        valid_raw[o]        = 1'b1;
                        sel_raw[o]          = owner_q[o];
                        pop_raw[owner_q[o]] = 1'b1;
                        if (bus.req_preamble[owner_q[o]][0]) begin
                            state_d[o] = IDLE;
                        end
                    end
                end
                default: state_d[o] = IDLE;
            endcase
            if (FlowControl == kFlowControlCreditBased) begin
                if (valid_raw[o] && !bus.credit_in[o]) begin
                    credits_d[o] = credits_q[o] - OneCredit;
                end else if (!valid_raw[o] && bus.credit_in[o] && credits_q[o] != MaxCredits) begin
                    credits_d[o] = credits_q[o] + OneCredit;
                end
            end else begin
                credits_d[o] = MaxCredits;
            end
        end
    end

    // Drive outputs, forcing the idle pattern while reset is held.
    always_comb begin
        bus.in_pop    = rst ? '0 : pop_raw;
        bus.out_valid = rst ? '0 : valid_raw;
        bus.out_sel   = rst ? '0 : sel_raw;
        for (int o = 0; o < 5; o++) begin
            bus.credits[o] = credits_q[o];
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (rst) begin
                state_q[o]   <= IDLE;
                owner_q[o]   <= '0;
                rr_q[o]      <= '0;
                credits_q[o] <= MaxCredits;
            end else begin
                state_q[o]   <= state_d[o];
                owner_q[o]   <= owner_d[o];
                rr_q[o]      <= rr_d[o];
                credits_q[o] <= credits_d[o];
            end
        end
    end

    // A credit returned to an output that already holds every credit is a protocol error.
    for (genvar o = 0; o < 5; o++) begin : g_credit_check
        if (FlowControl == kFlowControlCreditBased) begin : g_on
            credit_overflow: assert property (@(posedge clk) disable iff (rst)
                !(bus.credit_in[o] && !valid_raw[o] && credits_q[o] == MaxCredits));
        end
    end
endmodule
